// File: rtl/k_operand_sequencer.sv
// k_operand_sequencer
//
// Operand fetch sequencer for one instruction at a time. An instruction is
// accepted in IDLE, its rs1 and rs2 register-file entries are read on two
// consecutive cycles, the returned words are handed to external decode logic,
// and the decode results are registered and presented downstream with a
// valid/ready handshake. Register index 0 is never read; its operand is 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready instruction offer / accept (accept only in IDLE)
//   in_instr          instruction word; rs1 = [19:15], rs2 = [24:20]
//   rf_en/rf_addr     register-file read strobe and index
//   rf_rdata          read data, valid one cycle after rf_en
//   dec_instruction   instruction under decode (held register)
//   dec_loader        rs1 operand (held register)
//   dec_loader1       rs2 operand (held register)
//   dec_rs1/dec_rs2   combinational decode results
//   out_valid/out_ready  decoded operand pair handshake
//   out_rs1/out_rs2   registered decoded operands
//   busy              high whenever not IDLE
//   issue_cnt         completed output handshakes, wraps at 2^CNT_W

module k_operand_sequencer #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              rf_en,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [31:0]       dec_instruction,
  output logic [DATA_W-1:0] dec_loader,
  output logic [DATA_W-1:0] dec_loader1,
  input  logic [DATA_W-1:0] dec_rs1,
  input  logic [DATA_W-1:0] dec_rs2,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rs1,
  output logic [DATA_W-1:0] out_rs2,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  issue_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    DEC  = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [31:0]         instr_q,     instr_d;
  logic [DATA_W-1:0]   loader_q,    loader_d;
  logic [DATA_W-1:0]   loader1_q,   loader1_d;
  logic [DATA_W-1:0]   out_rs1_q,   out_rs1_d;
  logic [DATA_W-1:0]   out_rs2_q,   out_rs2_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;

  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;

  assign rs1_idx = instr_q[19:15];
  assign rs2_idx = instr_q[24:20];

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave a value undriven (no latches).
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    loader_d    = loader_q;
    loader1_d   = loader1_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_valid_d = out_valid_q;
    issue_cnt_d = issue_cnt_q;
    in_ready    = 1'b0;
    rf_en       = 1'b0;
    rf_addr     = '0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          instr_d = in_instr;
          state_d = RD_A;
        end
      end

      RD_A: begin
        // Index 0 is hard-wired zero: no read, and rf_addr stays 0.
        if (rs1_idx != 5'd0) begin
          rf_en   = 1'b1;
          rf_addr = IDX_W'(rs1_idx);
        end
        state_d = RD_B;
      end

      RD_B: begin
        if (rs2_idx != 5'd0) begin
          rf_en   = 1'b1;
          rf_addr = IDX_W'(rs2_idx);
        end
        // rf_rdata now carries the rs1 read issued in RD_A.
        loader_d = (rs1_idx == 5'd0) ? '0 : rf_rdata;
        state_d  = DEC;
      end

      DEC: begin
        // rf_rdata now carries the rs2 read issued in RD_B.
        loader1_d = (rs2_idx == 5'd0) ? '0 : rf_rdata;
        state_d   = OUT;
      end

      OUT: begin
        if (!out_valid_q) begin
          // First OUT cycle: both operands are final, register the decode.
          out_rs1_d   = dec_rs1;
          out_rs2_d   = dec_rs2;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      loader_q    <= '0;
      loader1_q   <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_valid_q <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      loader_q    <= loader_d;
      loader1_q   <= loader1_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_valid_q <= out_valid_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign dec_instruction = instr_q;
  assign dec_loader      = loader_q;
  assign dec_loader1     = loader1_q;
  assign out_valid       = out_valid_q;
  assign out_rs1         = out_rs1_q;
  assign out_rs2         = out_rs2_q;
  assign issue_cnt       = issue_cnt_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_k_operand_sequencer.sv
// Directed testbench for k_operand_sequencer (CNT_W = 4 so the counter wraps
// quickly). Provides a register-file model with one-cycle read latency that
// returns FFFFFFFF when not strobed, and a small combinational decode model:
//   dec_rs1 = instr[0] ? loader + loader1 : loader
//   dec_rs2 = loader1 ^ instr
module tb_k_operand_sequencer;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [31:0]       in_instr;
  logic              in_ready;
  logic              rf_en;
  logic [IDX_W-1:0]  rf_addr;
  logic [DATA_W-1:0] rf_rdata;
  logic [31:0]       dec_instruction;
  logic [DATA_W-1:0] dec_loader;
  logic [DATA_W-1:0] dec_loader1;
  logic [DATA_W-1:0] dec_rs1;
  logic [DATA_W-1:0] dec_rs2;
  logic              out_valid;
  logic [DATA_W-1:0] out_rs1;
  logic [DATA_W-1:0] out_rs2;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  issue_cnt;

  k_operand_sequencer #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_instr       (in_instr),
    .in_ready       (in_ready),
    .rf_en          (rf_en),
    .rf_addr        (rf_addr),
    .rf_rdata       (rf_rdata),
    .dec_instruction(dec_instruction),
    .dec_loader     (dec_loader),
    .dec_loader1    (dec_loader1),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .out_valid      (out_valid),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_ready      (out_ready),
    .busy           (busy),
    .issue_cnt      (issue_cnt)
  );

  always #5 clk = ~clk;

  // Register file model.
  logic [DATA_W-1:0] rf_mem [32];
  always @(posedge clk) begin
    rf_rdata <= rf_en ? rf_mem[rf_addr] : 32'hFFFF_FFFF;
  end

  // Decode model.
  assign dec_rs1 = dec_instruction[0] ? (dec_loader + dec_loader1) : dec_loader;
  assign dec_rs2 = dec_loader1 ^ dec_instruction;

  int cyc = 0;
  int rf_en_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_en) rf_en_cnt <= rf_en_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   base;
    logic seen;
    int   waited;
    int   prev_hs;
    int   hs_cyc;

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hDEAD_0000 | i;
    rf_mem[0] = 32'hFFFF_FFFF;
    rf_mem[3] = 32'hA5B6_C7D8;
    rf_mem[7] = 32'h1234_5678;

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    step(); step();

    // Reset state.
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rf_en",     rf_en, 0);
    check("rst_rf_addr",   rf_addr, 0);
    check("rst_busy",      busy, 0);
    check("rst_issue_cnt", issue_cnt, 0);
    check("rst_dec_instr", dec_instruction, 0);
    check("rst_loader",    dec_loader, 0);
    check("rst_loader1",   dec_loader1, 0);
    check("rst_out_rs1",   out_rs1, 0);
    check("rst_out_rs2",   out_rs2, 0);

    // rst wins over a concurrent in_valid.
    in_valid = 1'b1; in_instr = 32'h0071_8001;
    step();
    check("rst_prio_busy",  busy, 0);
    check("rst_prio_instr", dec_instruction, 0);

    // Reset while in RD_B discards the instruction.
    rst = 1'b0;
    step();                                 // RD_A
    in_valid = 1'b0;
    check("rdb_rst_a_addr", rf_addr, 3);
    step();                                 // RD_B
    check("rdb_rst_b_addr", rf_addr, 7);
    rst = 1'b1;
    step();
    check("rdb_rst_busy",      busy, 0);
    check("rdb_rst_in_ready",  in_ready, 1);
    check("rdb_rst_out_valid", out_valid, 0);
    check("rdb_rst_cnt",       issue_cnt, 0);
    check("rdb_rst_instr",     dec_instruction, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("rdb_rst_no_valid", seen, 0);
    check("rdb_rst_cnt_later", issue_cnt, 0);

    // Basic issue: rs1=3, rs2=7, bit0=1, out_ready held high throughout.
    in_valid = 1'b1; in_instr = 32'h0071_8001;
    check("a_idle_ready", in_ready, 1);
    step();                                 // T+1 RD_A
    in_valid = 1'b0;
    check("a_rda_en",    rf_en, 1);
    check("a_rda_addr",  rf_addr, 3);
    check("a_rda_ready", in_ready, 0);
    check("a_rda_busy",  busy, 1);
    step();                                 // T+2 RD_B
    check("a_rdb_en",   rf_en, 1);
    check("a_rdb_addr", rf_addr, 7);
    step();                                 // T+3 DEC
    check("a_dec_en",     rf_en, 0);
    check("a_dec_addr",   rf_addr, 0);
    check("a_dec_loader", dec_loader, 32'hA5B6_C7D8);
    step();                                 // T+4 OUT, not yet valid
    check("a_out1_valid",   out_valid, 0);
    check("a_out1_loader",  dec_loader, 32'hA5B6_C7D8);
    check("a_out1_loader1", dec_loader1, 32'h1234_5678);
    check("a_out1_en",      rf_en, 0);
    step();                                 // T+5
    check("a_valid",   out_valid, 1);
    check("a_out_rs1", out_rs1, 32'hB7EB_1E50);
    check("a_out_rs2", out_rs2, 32'h1245_D679);
    check("a_cnt_pre", issue_cnt, 0);
    step();                                 // T+6 back in IDLE
    check("a_idle_busy",  busy, 0);
    check("a_idle_valid", out_valid, 0);
    check("a_cnt",        issue_cnt, 1);

    // Both indices zero: no reads, zero operands.
    base = rf_en_cnt;
    in_valid = 1'b1; in_instr = 32'h0000_0013;
    step();                                 // RD_A
    in_valid = 1'b0;
    check("z_rda_en",   rf_en, 0);
    check("z_rda_addr", rf_addr, 0);
    step(); step(); step();                 // OUT first cycle
    check("z_loader",  dec_loader, 0);
    check("z_loader1", dec_loader1, 0);
    step();
    check("z_valid",    out_valid, 1);
    check("z_out_rs1",  out_rs1, 0);
    check("z_out_rs2",  out_rs2, 32'h0000_0013);
    check("z_no_reads", rf_en_cnt - base, 0);
    step();
    check("z_cnt", issue_cnt, 2);

    // rs1 == rs2 == 7, with downstream back-pressure and in_valid pulsed.
    out_ready = 1'b0;
    base = rf_en_cnt;
    in_valid = 1'b1; in_instr = 32'h0073_8000;
    step();                                 // RD_A
    in_valid = 1'b0;
    check("s_rda_addr", rf_addr, 7);
    step();                                 // RD_B
    check("s_rdb_addr", rf_addr, 7);
    step(); step(); step();                 // T+5
    check("s_valid",     out_valid, 1);
    check("s_out_rs1",   out_rs1, 32'h1234_5678);
    check("s_out_rs2",   out_rs2, 32'h1247_D678);
    check("s_two_reads", rf_en_cnt - base, 2);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_instr = 32'h0071_8001;
      step();
      check("bp_valid",    out_valid, 1);
      check("bp_out_rs1",  out_rs1, 32'h1234_5678);
      check("bp_out_rs2",  out_rs2, 32'h1247_D678);
      check("bp_in_ready", in_ready, 0);
      check("bp_instr",    dec_instruction, 32'h0073_8000);
    end
    in_valid = 1'b0;
    check("bp_cnt_held", issue_cnt, 2);
    out_ready = 1'b1;
    step();
    check("bp_rel_busy",  busy, 0);
    check("bp_rel_ready", in_ready, 1);
    check("bp_rel_cnt",   issue_cnt, 3);
    check("bp_rel_instr", dec_instruction, 32'h0073_8000);

    // 17 back-to-back instructions: counter wrap and issue interval.
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0071_8001; out_ready = 1'b1;
    step();
    check("w_rst_cnt",  issue_cnt, 0);
    check("w_rst_busy", busy, 0);
    rst = 1'b0;
    prev_hs = 0;
    for (int k = 1; k <= 17; k++) begin
      waited = 0;
      while (!out_valid && waited < 20) begin
        step();
        waited++;
      end
      check("w_wait_valid", out_valid, 1);
      hs_cyc = cyc;
      if (k > 1) check("w_interval", 64'(hs_cyc - prev_hs), 6);
      prev_hs = hs_cyc;
      step();
      check("w_cnt", issue_cnt, 64'(k % 16));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/k_operand_sequencer.md
K_OPERAND_SEQUENCER -- requirements
Module: k_operand_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: width of operand words and the decode datapath.
REQ-002 Parameter IDX_W, default 5: register-file index width.
REQ-003 Parameter CNT_W, default 16: width of the issue counter.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  an instruction is offered.
REQ-007 in_instr  input  32  offered instruction; rs1 index = [19:15], rs2 index = [24:20].
REQ-008 in_ready  output  1  sequencer accepts in_instr this cycle.
REQ-009 rf_en  output  1  register-file read strobe.
REQ-010 rf_addr  output  IDX_W  register-file read index.
REQ-011 rf_rdata  input  DATA_W  read data, valid exactly one cycle after rf_en.
REQ-012 dec_instruction, dec_loader, dec_loader1  output  32/DATA_W/DATA_W  drive the decode-logic inputs.
REQ-013 dec_rs1, dec_rs2  input  DATA_W  combinational decode-logic results.
REQ-014 out_valid  output  1  out_rs1/out_rs2 hold a decoded operand pair.
REQ-015 out_rs1, out_rs2  output  DATA_W  registered decoded operands.
REQ-016 out_ready  input  1  downstream accepts the operand pair.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 issue_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-019 The FSM SHALL have states IDLE, RD_A, RD_B, DEC, OUT.
REQ-020 in_ready SHALL be 1 only in IDLE; in_valid in any other state is ignored.
REQ-021 IDLE with in_valid=1: latch in_instr into instr_q, go to RD_A.
REQ-022 RD_A: rf_addr=instr_q[19:15], rf_en=1 unless index is 0; go to RD_B.
REQ-023 RD_B: rf_addr=instr_q[24:20], rf_en=1 unless index is 0; capture rf_rdata into loader_q, or 0 if the rs1 index is 0; go to DEC.
REQ-024 DEC: capture rf_rdata into loader1_q, or 0 if the rs2 index is 0; go to OUT.
REQ-025 dec_instruction=instr_q, dec_loader=loader_q and dec_loader1=loader1_q in every state; dec_loader1 reflects the DEC capture from the first OUT cycle.
REQ-026 On OUT entry, out_rs1/out_rs2 SHALL register dec_rs1/dec_rs2 computed from the final operands; this is a one-cycle register stage, so out_valid rises one cycle into OUT.
REQ-027 OUT: out_valid=1 once the results are registered; out_rs1/out_rs2 SHALL stay stable while out_ready=0.
REQ-028 OUT with out_valid=1 and out_ready=1: handshake completes, issue_cnt increments, go to IDLE.
REQ-029 Latency: instruction accepted in cycle T gives out_valid=1 at cycle T+5; minimum issue interval is 6 cycles.
REQ-030 rf_en SHALL be 0 in IDLE, DEC and OUT; rf_addr SHALL be 0 when rf_en=0.
REQ-031 issue_cnt SHALL wrap from 2^CNT_W-1 to 0 without saturation or a flag.
REQ-032 rs1 index equal to rs2 index SHALL still issue two reads and return identical operands.
REQ-033 out_ready asserted outside OUT, or before out_valid, SHALL have no effect.

Reset
REQ-034 When rst=1 at a clock edge: state=IDLE, in_ready=1, out_valid=0, rf_en=0, rf_addr=0, busy=0, issue_cnt=0, and instr_q, loader_q, loader1_q, out_rs1, out_rs2 all 0.
REQ-035 Reset in any state, including mid-read and OUT, SHALL discard the in-flight instruction with no handshake and no count.
REQ-036 rst SHALL take priority over every concurrent in_valid or out_ready event.

Verification
REQ-037 rf[3]=A5B6C7D8, rf[7]=12345678, instr rs1=3 rs2=7 bit0=1, out_ready=1 -> rf_addr 3 then 7; dec_loader=A5B6C7D8 and dec_loader1=12345678 during OUT; out_valid at T+5 with out_rs1/out_rs2 equal to the decode model; issue_cnt=1.
REQ-038 instr with rs1=0 rs2=0, rf returns FFFFFFFF -> rf_en never asserted, dec_loader=dec_loader1=0.
REQ-039 out_ready held 0 for 10 cycles in OUT, with in_valid pulsed -> out data stable, in_ready=0, instruction not accepted; on release, IDLE next cycle.
REQ-040 rst asserted in RD_B -> next cycle IDLE, out_valid=0, issue_cnt unchanged, no spurious out_valid later.
REQ-041 CNT_W=4, 17 back-to-back instructions -> issue_cnt reads 0 after the 16th handshake and 1 after the 17th; every interval is 6 cycles.
